// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-strobed h/v counters with registered sync,
// visible-area flag, line/frame start pulses and a free-running frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  output logic [9:0] xPos,
  output logic [9:0] yPos,
  output logic       horizSync,
  output logic       vertSync,
  output logic       valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] x_q, y_q;
  logic       hsync_q, vsync_q, valid_q, line_q, frame_q;
  logic [7:0] fcnt_q;

  logic [9:0] x_d, y_d;
  logic       hsync_d, vsync_d, valid_d, line_d, frame_d;

  // Next raster position if this edge is strobed
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  // Decode from the next position so registered outputs line up with the counters
  always_comb begin
    valid_d = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    line_d  = (x_d == '0);
    frame_d = (x_d == '0) && (y_d == '0);
  end

  // State and output registers; pulses clear on any edge without a strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      valid_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= '0;
    end else if (strobe) begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      if (frame_d) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign xPos        = x_q;
  assign yPos        = y_q;
  assign horizSync   = hsync_q;
  assign vertSync    = vsync_q;
  assign valid       = valid_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so that full
// frames and the 8-bit frame counter wrap fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic SPOL = 1'b0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vld;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       strobe;
  logic [9:0] xPos, yPos;
  logic       horizSync, vertSync, valid, line_start, frame_start;
  logic [7:0] frame_cnt;

  exp_t sb_q[$];
  int   n;       // strobes accepted since the last reset
  int   n_cmp;
  int   n_err;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(SPOL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .strobe     (strobe),
    .xPos       (xPos),
    .yPos       (yPos),
    .horizSync  (horizSync),
    .vertSync   (vertSync),
    .valid      (valid),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the raster is a linear pixel index; reset sits one pixel before (0,0).
  function automatic exp_t model(input int cnt, input bit stepped);
    exp_t e;
    int p, x, y;
    p = (cnt == 0) ? FRAME - 1 : (cnt - 1) % FRAME;
    x = p % HT;
    y = p / HT;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.vld = (x < HV) && (y < VV);
    e.hs  = (x >= HV + HF && x < HV + HF + HS) ? SPOL : ~SPOL;
    e.vs  = (y >= VV + VF && y < VV + VF + VS) ? SPOL : ~SPOL;
    e.ls  = stepped && (x == 0);
    e.fs  = stepped && (p == 0);
    e.fc  = 8'(((cnt + FRAME - 1) / FRAME) % 256);
    return e;
  endfunction

  // One clock: drive at negedge, record the expected post-edge state at posedge
  task automatic cycle(input logic s, input logic r);
    @(negedge clk);
    strobe = s;
    reset  = r;
    @(posedge clk);
    if (reset) n = 0;
    else if (s) n++;
    sb_q.push_back(model(n, !reset && s));
  endtask

  task automatic run_to(input int tx, input int ty);
    exp_t e;
    for (int i = 0; i < FRAME + 2; i++) begin
      e = model(n, 1'b0);
      if (int'(e.x) == tx && int'(e.y) == ty) return;
      cycle(1'b1, 1'b0);
    end
    n_cmp++;
    n_err++;
    $display("FAIL run_to: position (%0d,%0d) not reached within one frame", tx, ty);
  endtask

  // Reset raised midway between clock edges; the monitor fires on the reset edge
  task automatic async_reset();
    @(negedge clk);
    strobe = 1'b0;
    #2;
    n = 0;
    sb_q.push_back(model(0, 1'b0));
    reset = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        a = '{x: xPos, y: yPos, hs: horizSync, vs: vertSync, vld: valid,
              ls: line_start, fs: frame_start, fc: frame_cnt};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got x=%0d y=%0d hs=%b vs=%b v=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b v=%b ls=%b fs=%b fc=%0d",
                   $time, a.x, a.y, a.hs, a.vs, a.vld, a.ls, a.fs, a.fc,
                   e.x, e.y, e.hs, e.vs, e.vld, e.ls, e.fs, e.fc);
        end
      end
    end
  end

  initial begin
    n = 0;
    n_cmp = 0;
    n_err = 0;
    strobe = 1'b0;
    reset = 1'b1;

    // Held in reset, then released with no strobes
    repeat (3) cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0);

    // Strobe every 4th clock across a couple of lines
    for (int i = 0; i < 4 * HT * 2 + 8; i++) cycle((i % 4) == 3, 1'b0);

    // Random strobe density over several frames
    for (int i = 0; i < 6 * FRAME; i++) cycle(1'($urandom_range(0, 1)), 1'b0);

    // Freeze inside both sync regions, then resume
    run_to(HV + HF + 1, VV + VF + VS - 1);
    repeat (100) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);

    // Strobe every clock long enough to wrap the frame counter
    for (int i = 0; i < 258 * FRAME; i++) cycle(1'b1, 1'b0);

    // Asynchronous reset mid-frame, then restart
    run_to(HV / 2, VV / 2);
    async_reset();
    repeat (2) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    for (int i = 0; i < 2 * HT; i++) cycle(1'($urandom_range(0, 1)), 1'b0);

    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
